pe_col_driver: RTL and testbench

//  Head/tail driver for one systolic column of GF processing elements. Accepts LOAD/MAC/DRAIN

---
 rtl/pe_col_driver.sv | 154 +++++++++++++++
 tb/tb_pe_col_driver.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pe_col_driver.sv
// Head/tail driver for one systolic column of GF processing elements: turns LOAD/MAC/DRAIN
// commands into registered column-head beats and collects tail results after the column latency.
module pe_col_driver #(
  parameter int GF_BIT = 4,
  parameter int N_PE   = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [GF_BIT-1:0] in_data,
  input  logic [GF_BIT-1:0] in_coef,
  output logic              start_out,
  output logic [1:0]        gauss_op_out,
  output logic [GF_BIT-1:0] data_out,
  output logic [GF_BIT-1:0] dataB_out,
  input  logic [GF_BIT-1:0] tail_data,
  output logic              res_valid,
  output logic [GF_BIT-1:0] res_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [1:0] G_NOP   = 2'b00;
  localparam logic [1:0] G_LOAD  = 2'b01;
  localparam logic [1:0] G_MAC   = 2'b10;
  localparam logic [1:0] G_DRAIN = 2'b11;

  localparam int CNT_W = $clog2(N_PE + 2);
  localparam logic [CNT_W-1:0] DRAIN_TAIL = CNT_W'(N_PE);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(N_PE + 1);

  state_t             state_reg;
  logic [LEN_W-1:0]   beats_left_reg;
  logic               first_reg;
  logic [CNT_W-1:0]   drain_cnt_reg;
  logic [N_PE-1:0]    vsr_reg;
  logic               beat;
  logic               mac_issue;

  assign cmd_ready = (state_reg == S_IDLE);
  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_DONE);
  assign in_ready  = ((state_reg == S_LOAD) || (state_reg == S_MAC)) && (beats_left_reg != '0);
  assign beat      = in_valid & in_ready;

  // The column-head register is stage zero; the valid bit leaves vsr_reg in the
  // cycle the tail holds that beat's result.
  assign mac_issue = (gauss_op_out == G_MAC);

  always_ff @(posedge clk) begin
    if (rst) begin
      vsr_reg <= '0;
    end else begin
      vsr_reg <= {vsr_reg[N_PE-2:0], mac_issue};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      beats_left_reg <= '0;
      first_reg      <= 1'b0;
      drain_cnt_reg  <= '0;
      start_out      <= 1'b0;
      gauss_op_out   <= G_NOP;
      data_out       <= '0;
      dataB_out      <= '0;
      res_valid      <= 1'b0;
      res_data       <= '0;
    end else begin
      start_out    <= 1'b0;
      gauss_op_out <= G_NOP;
      data_out     <= '0;
      dataB_out    <= '0;
      res_valid    <= 1'b0;

      if (vsr_reg[N_PE-1]) begin
        res_valid <= 1'b1;
        res_data  <= tail_data;
      end

      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) begin
            beats_left_reg <= cmd_len;
            first_reg      <= 1'b1;
            drain_cnt_reg  <= '0;
            case (cmd_op)
              2'b00:   state_reg <= (cmd_len == '0) ? S_DONE : S_LOAD;
              2'b01:   state_reg <= (cmd_len == '0) ? S_DONE : S_MAC;
              default: begin
                state_reg    <= S_DRAIN;
                gauss_op_out <= G_DRAIN;
              end
            endcase
          end
        end

        S_LOAD: begin
          if (beat) begin
            start_out      <= first_reg;
            gauss_op_out   <= G_LOAD;
            data_out       <= in_data;
            dataB_out      <= in_coef;
            first_reg      <= 1'b0;
            beats_left_reg <= beats_left_reg - 1'b1;
          end else if (beats_left_reg == '0) begin
            state_reg <= S_DONE;
          end
        end

        S_MAC: begin
          if (beat) begin
            gauss_op_out   <= G_MAC;
            dataB_out      <= in_coef;
            beats_left_reg <= beats_left_reg - 1'b1;
          end else if ((beats_left_reg == '0) && (vsr_reg == '0) && !mac_issue) begin
            state_reg <= S_DONE;
          end
        end

        S_DRAIN: begin
          drain_cnt_reg <= drain_cnt_reg + 1'b1;
          // Tail shows PE N_PE-1 first, then each upstream PE one cycle later.
          if ((drain_cnt_reg != '0) && (drain_cnt_reg <= DRAIN_TAIL)) begin
            res_valid <= 1'b1;
            res_data  <= tail_data;
          end
          if (drain_cnt_reg == DRAIN_LAST) begin
            state_reg <= S_DONE;
          end
        end

        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_col_driver.sv
// Directed bench for pe_col_driver with a 4-PE column: a per-cycle vector table for
// LOAD/DRAIN plus hand-written MAC, zero-length and mid-command reset sequences.
module tb_pe_col_driver;
  localparam int GF  = 4;
  localparam int NPE = 4;
  localparam int LW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [LW-1:0] cmd_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [GF-1:0] in_data = '0;
  logic [GF-1:0] in_coef = '0;
  logic          start_out;
  logic [1:0]    gauss_op_out;
  logic [GF-1:0] data_out;
  logic [GF-1:0] dataB_out;
  logic [GF-1:0] tail_data = '0;
  logic          res_valid;
  logic [GF-1:0] res_data;
  logic          busy;
  logic          done;

  pe_col_driver #(.GF_BIT(GF), .N_PE(NPE), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_coef(in_coef),
    .start_out(start_out), .gauss_op_out(gauss_op_out), .data_out(data_out),
    .dataB_out(dataB_out), .tail_data(tail_data), .res_valid(res_valid),
    .res_data(res_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct {
    logic          cv;
    logic [1:0]    op;
    logic [LW-1:0] len;
    logic          iv;
    logic [GF-1:0] id, ic, td;
    logic          crdy, irdy, st;
    logic [1:0]    g;
    logic [GF-1:0] d, db;
    logic          rv;
    logic [GF-1:0] rd;
    logic          bsy, dn;
  } vec_t;

  function automatic vec_t mk(input int cv, op, len, iv, id, ic, td,
                              input int crdy, irdy, st, g, d, db, rv, rd, bsy, dn);
    vec_t v;
    v.cv = 1'(cv); v.op = 2'(op); v.len = LW'(len); v.iv = 1'(iv);
    v.id = GF'(id); v.ic = GF'(ic); v.td = GF'(td);
    v.crdy = 1'(crdy); v.irdy = 1'(irdy); v.st = 1'(st); v.g = 2'(g);
    v.d = GF'(d); v.db = GF'(db); v.rv = 1'(rv); v.rd = GF'(rd);
    v.bsy = 1'(bsy); v.dn = 1'(dn);
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    int res_cnt;
    logic exp_rv;

    //                cv op len iv id ic td   crdy irdy st g  d  db rv rd bsy dn
    tbl[0]  = mk(1, 0, 3, 0, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0, 0,  0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 1, 2, 0,    0, 1, 0, 0, 0, 0, 0, 0,  1, 0);
    tbl[2]  = mk(0, 0, 0, 1, 3, 4, 0,    0, 1, 1, 1, 1, 2, 0, 0,  1, 0);
    tbl[3]  = mk(0, 0, 0, 1, 5, 6, 0,    0, 1, 0, 1, 3, 4, 0, 0,  1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 5, 6, 0, 0,  1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0,  1, 1);
    tbl[6]  = mk(1, 2, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0, 0,  0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 3, 0, 0, 0, 0,  1, 0);
    tbl[8]  = mk(0, 0, 0, 1, 7, 7, 10,   0, 0, 0, 0, 0, 0, 0, 0,  1, 0);
    tbl[9]  = mk(1, 0, 5, 0, 0, 0, 11,   0, 0, 0, 0, 0, 0, 1, 10, 1, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 12,   0, 0, 0, 0, 0, 0, 1, 11, 1, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 13,   0, 0, 0, 0, 0, 0, 1, 12, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 1, 13, 1, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 13, 1, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0, 13, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Reset state held over idle cycles
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("idle%0d.cmd_ready", k), cmd_ready, 1);
      chk($sformatf("idle%0d.busy", k), busy, 0);
      chk($sformatf("idle%0d.outs", k),
          {start_out, gauss_op_out, data_out, dataB_out, res_valid, res_data, done, in_ready}, 0);
    end

    // LOAD of three beats followed by a DRAIN, one table row per cycle
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      cmd_valid = tbl[i].cv; cmd_op = tbl[i].op; cmd_len = tbl[i].len;
      in_valid = tbl[i].iv; in_data = tbl[i].id; in_coef = tbl[i].ic; tail_data = tbl[i].td;
      chk($sformatf("row%0d.cmd_ready", i), cmd_ready, tbl[i].crdy);
      chk($sformatf("row%0d.in_ready", i), in_ready, tbl[i].irdy);
      chk($sformatf("row%0d.start", i), start_out, tbl[i].st);
      chk($sformatf("row%0d.gauss_op", i), gauss_op_out, tbl[i].g);
      chk($sformatf("row%0d.data", i), data_out, tbl[i].d);
      chk($sformatf("row%0d.dataB", i), dataB_out, tbl[i].db);
      chk($sformatf("row%0d.res_valid", i), res_valid, tbl[i].rv);
      chk($sformatf("row%0d.res_data", i), res_data, tbl[i].rd);
      chk($sformatf("row%0d.busy", i), busy, tbl[i].bsy);
      chk($sformatf("row%0d.done", i), done, tbl[i].dn);
    end

    // MAC len=4 with a stall on the second beat slot; tail_data tracks the cycle index
    res_cnt = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      cmd_valid = (k == 0); cmd_op = 2'b01; cmd_len = 8'd4;
      in_valid = (k >= 1) && (k != 2); in_data = 4'hF; in_coef = GF'(k + 1);
      tail_data = GF'(k);
      exp_rv = (k == 7) || (k == 9) || (k == 10) || (k == 11);
      chk($sformatf("mac%0d.in_ready", k), in_ready, int'(k >= 1 && k <= 5));
      chk($sformatf("mac%0d.gauss_op", k), gauss_op_out,
          (k == 2 || k == 4 || k == 5 || k == 6) ? 2 : 0);
      chk($sformatf("mac%0d.dataB", k), dataB_out,
          (k == 2 || k == 4 || k == 5 || k == 6) ? k : 0);
      chk($sformatf("mac%0d.data_start", k), {start_out, data_out}, 0);
      chk($sformatf("mac%0d.res_valid", k), res_valid, int'(exp_rv));
      if (exp_rv) chk($sformatf("mac%0d.res_data", k), res_data, k - 1);
      chk($sformatf("mac%0d.done", k), done, int'(k == 12));
      if (res_valid) res_cnt++;
    end
    chk("mac.result_count", res_cnt, 4);

    // Zero-length LOAD then zero-length MAC, in_valid held high throughout
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cmd_valid = (k == 0) || (k == 2); cmd_op = (k == 0) ? 2'b00 : 2'b01; cmd_len = '0;
      in_valid = 1'b1; in_data = 4'h3; in_coef = 4'h4; tail_data = '0;
      chk($sformatf("zero%0d.done", k), done, int'(k == 1 || k == 3));
      chk($sformatf("zero%0d.in_ready", k), in_ready, 0);
      chk($sformatf("zero%0d.cmd_ready", k), cmd_ready, int'(k == 0 || k == 2 || k == 4));
      chk($sformatf("zero%0d.gauss_op", k), gauss_op_out, 0);
    end

    // Reset during MAC with two results in flight, then a normal LOAD of one beat
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      rst = (k == 4);
      cmd_valid = (k == 0) || (k == 10); cmd_op = (k == 0) ? 2'b01 : 2'b00; cmd_len = (k == 0) ? 8'd2 : 8'd1;
      in_valid = (k >= 1 && k <= 3) || (k == 11);
      in_data = (k == 11) ? 4'h9 : 4'h1; in_coef = (k == 11) ? 4'h3 : 4'h5; tail_data = 4'h7;
      if (k == 3) chk("rst3.gauss_op", gauss_op_out, 2);
      if (k == 5) begin
        chk("rst5.cmd_ready", cmd_ready, 1);
        chk("rst5.busy", busy, 0);
        chk("rst5.outs", {start_out, gauss_op_out, data_out, dataB_out, res_valid, res_data, done}, 0);
      end
      if (k >= 5) begin
        chk($sformatf("rst%0d.res_valid", k), res_valid, 0);
        chk($sformatf("rst%0d.done", k), done, int'(k == 13));
      end
      if (k == 12) begin
        chk("rst12.start", start_out, 1);
        chk("rst12.gauss_op", gauss_op_out, 1);
        chk("rst12.data", data_out, 9);
        chk("rst12.dataB", dataB_out, 3);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
